conv_out_packer: RTL and testbench

- Downstream stage of the conv datapath: consumes the per-pixel signed accumulator stream the conv core produces and requantises each value (round, shift, optional ReLU, int8 saturate).
- Packs four results per 32-bit word and drives the master AXI-Stream toward DMA.
- Generates TUSER, TKEEP and TLAST, and pulses done after the final beat so the APB status/clk_counter can close the measurement.

---
 rtl/conv_out_packer.sv | 209 ++++++++++++++++++++
 tb/tb_conv_out_packer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_packer.sv
`timescale 1ns/1ps
// conv_out_packer
// Requantises the conv core's signed accumulator stream to int8 (round half up,
// arithmetic shift, optional ReLU, saturate) and packs four results per 32-bit
// AXI-Stream beat toward DMA, with TUSER on the first beat, TLAST/TKEEP on the
// final beat and a one-cycle done pulse after the final handshake.
//
// Ports:
//   CLK, RESET                 clock, async active-high reset
//   cfg_start                  pulse: latch config and start a frame (IDLE only)
//   cfg_out_ch                 output channel count
//   cfg_feature_length         output map side length
//   cfg_shift, cfg_relu_en     requant shift amount and ReLU enable
//   acc_valid/acc_data/acc_ready   accumulator input handshake
//   M_AXIS_*                   packed int8x4 master stream
//   busy                       frame in progress (RUN or DRAIN)
//   done                       one-cycle completion pulse
module conv_out_packer #(
  parameter int unsigned ACC_WIDTH              = 32,
  parameter int unsigned CH_WIDTH               = 9,
  parameter int unsigned LEN_WIDTH              = 6,
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic                                  cfg_start,
  input  logic [CH_WIDTH-1:0]                   cfg_out_ch,
  input  logic [LEN_WIDTH-1:0]                  cfg_feature_length,
  input  logic [4:0]                            cfg_shift,
  input  logic                                  cfg_relu_en,
  input  logic                                  acc_valid,
  input  logic [ACC_WIDTH-1:0]                  acc_data,
  output logic                                  acc_ready,
  input  logic                                  M_AXIS_TREADY,
  output logic                                  M_AXIS_TVALID,
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
  output logic                                  M_AXIS_TLAST,
  output logic                                  M_AXIS_TUSER,
  output logic                                  busy,
  output logic                                  done
);

  localparam int unsigned TOT_W  = CH_WIDTH + 2 * LEN_WIDTH;
  localparam int unsigned EXT_W  = ACC_WIDTH + 1;
  localparam int unsigned DATA_W = C_S00_AXIS_TDATA_WIDTH;
  localparam int unsigned KEEP_W = C_S00_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned PACK_W = DATA_W - 8;

  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'(127);
  localparam logic signed [EXT_W-1:0] SAT_MIN = -(EXT_W'(128));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [TOT_W-1:0]   total_q;
  logic [TOT_W-1:0]   count_q;
  logic [4:0]         shift_q;
  logic               relu_q;
  logic [PACK_W-1:0]  pack_q;
  logic               first_q;

  logic [1:0]         lane_c;
  logic               last_val_c;
  logic               completes_c;
  logic               out_free_c;
  logic               accept_c;
  logic [7:0]         q_byte_c;
  logic [DATA_W-1:0]  word_c;
  logic [KEEP_W-1:0]  keep_c;
  logic [TOT_W-1:0]   total_c;

  // Round half up, arithmetic shift, optional ReLU, saturate to int8.
  function automatic logic [7:0] requant(input logic [ACC_WIDTH-1:0] v,
                                         input logic [4:0]           sh,
                                         input logic                 relu);
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] res;
    logic [7:0]              out;
    ext = $signed({v[ACC_WIDTH-1], v});
    rnd = '0;
    if (sh != 5'd0) begin
      rnd = EXT_W'(1) << (sh - 5'd1);
    end
    sum = ext + rnd;
    res = sum >>> sh;
    if (relu && res[EXT_W-1]) begin
      res = '0;
    end
    if (res > SAT_MAX) begin
      out = 8'h7F;
    end else if (res < SAT_MIN) begin
      out = 8'h80;
    end else begin
      out = res[7:0];
    end
    return out;
  endfunction

  assign total_c = TOT_W'(cfg_out_ch) * TOT_W'(cfg_feature_length) * TOT_W'(cfg_feature_length);

  assign lane_c      = count_q[1:0];
  assign last_val_c  = (count_q == total_q - TOT_W'(1));
  assign completes_c = (lane_c == 2'd3) || last_val_c;
  assign out_free_c  = !M_AXIS_TVALID || M_AXIS_TREADY;

  // A byte that closes a word (lane 3 or the frame's last value) needs the
  // output register free; other lanes only touch the pack register.
  assign acc_ready = (state_q == S_RUN) && (count_q < total_q) &&
                     (!completes_c || out_free_c);
  assign accept_c  = acc_valid && acc_ready;
  assign q_byte_c  = requant(acc_data, shift_q, relu_q);

  // Merge the new byte into the partial word; lanes above it are still zero.
  always_comb begin
    word_c = {8'h00, pack_q};
    word_c[{lane_c, 3'b000} +: 8] = q_byte_c;
    case (lane_c)
      2'd0:    keep_c = 4'b0001;
      2'd1:    keep_c = 4'b0011;
      2'd2:    keep_c = 4'b0111;
      default: keep_c = 4'b1111;
    endcase
  end

  // Frame FSM, counters, pack register and registered stream outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      total_q       <= '0;
      count_q       <= '0;
      shift_q       <= '0;
      relu_q        <= 1'b0;
      pack_q        <= '0;
      first_q       <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TKEEP  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TUSER  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;

      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        M_AXIS_TVALID <= 1'b0;
      end

      if (accept_c) begin
        count_q <= count_q + TOT_W'(1);
        if (completes_c) begin
          M_AXIS_TDATA  <= word_c;
          M_AXIS_TKEEP  <= keep_c;
          M_AXIS_TLAST  <= last_val_c;
          M_AXIS_TUSER  <= first_q;
          M_AXIS_TVALID <= 1'b1;
          first_q       <= 1'b0;
          pack_q        <= '0;
        end else begin
          pack_q <= word_c[PACK_W-1:0];
        end
      end

      case (state_q)
        S_IDLE: begin
          if (cfg_start) begin
            total_q <= total_c;
            shift_q <= cfg_shift;
            relu_q  <= cfg_relu_en;
            count_q <= '0;
            pack_q  <= '0;
            first_q <= 1'b1;
            if (total_c == '0) begin
              state_q <= S_DONE;
              done    <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (accept_c && last_val_c) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) begin
            state_q <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_out_packer.sv
`timescale 1ns/1ps
// Bench for conv_out_packer: directed frames, a spec-level model of the
// expected beat stream, and one negedge compare process.
module tb_conv_out_packer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        cfg_start = 1'b0;
  logic [8:0]  cfg_out_ch = '0;
  logic [5:0]  cfg_feature_length = '0;
  logic [4:0]  cfg_shift = '0;
  logic        cfg_relu_en = 1'b0;
  logic        acc_valid = 1'b0;
  logic [31:0] acc_data = '0;
  logic        acc_ready;
  logic        M_AXIS_TREADY = 1'b1;
  logic        M_AXIS_TVALID;
  logic [31:0] M_AXIS_TDATA;
  logic [3:0]  M_AXIS_TKEEP;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TUSER;
  logic        busy;
  logic        done;

  conv_out_packer #(
    .ACC_WIDTH(32), .CH_WIDTH(9), .LEN_WIDTH(6), .C_S00_AXIS_TDATA_WIDTH(32)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .cfg_start(cfg_start), .cfg_out_ch(cfg_out_ch),
    .cfg_feature_length(cfg_feature_length), .cfg_shift(cfg_shift),
    .cfg_relu_en(cfg_relu_en),
    .acc_valid(acc_valid), .acc_data(acc_data), .acc_ready(acc_ready),
    .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TUSER(M_AXIS_TUSER),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  beat_t              exp_q[$];
  logic signed [31:0] stim[$];
  beat_t              last_hs;
  int                 n_tests = 0;
  int                 n_fail = 0;
  int                 beats_seen = 0;
  bit                 rand_ready = 1'b0;
  bit                 zero_frame = 1'b0;
  bit                 done_due = 1'b0;
  bit                 done_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // int8 result of one accumulator value using floor division.
  function automatic logic [7:0] model_byte(input logic signed [31:0] v, input int sh, input bit relu);
    longint d, t, q;
    d = longint'(1) << sh;
    t = longint'(v) + ((sh > 0) ? d / 2 : longint'(0));
    q = t / d;
    if ((t % d != 0) && (t < 0)) q = q - 1;
    if (relu && q < 0) q = 0;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return 8'(q);
  endfunction

  // Expected beat stream for the first `total` stimulus values.
  task automatic build_model(input int total, input int sh, input bit relu);
    logic [31:0] w;
    beat_t b;
    exp_q.delete();
    w = '0;
    for (int i = 0; i < total; i++) begin
      w[8*(i%4) +: 8] = model_byte(stim[i], sh, relu);
      if ((i % 4 == 3) || (i == total - 1)) begin
        b.data = w;
        b.keep = 4'((1 << ((i % 4) + 1)) - 1);
        b.last = (i == total - 1);
        b.user = (i < 4);
        exp_q.push_back(b);
        w = '0;
      end
    end
  endtask

  // Downstream ready: always 1, or a random coin per cycle.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      M_AXIS_TREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every valid cycle shows the head expected beat; done
  // pulses exactly one cycle after a TLAST handshake or a zero-size start.
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET) begin
        done_due = 1'b0;
      end else begin
        if (M_AXIS_TVALID) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(M_AXIS_TVALID), 64'(0));
          end else begin
            check("beat", 64'({M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TUSER}), 64'(exp_q[0]));
          end
          if (M_AXIS_TREADY) begin
            last_hs = {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TUSER};
            beats_seen++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          end
        end
        check("done", 64'(done), 64'(done_due));
        if (done) done_seen = 1'b1;
        done_due = (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) || (cfg_start && zero_frame);
      end
    end
  end

  task automatic run_frame(input int ch, input int len, input int sh, input bit relu,
                           input bit rnd, input int abort_after, input string tag);
    int total;
    int i;
    int cyc;
    bit acc;
    bit aborted;
    total = ch * len * len;
    i = 0;
    cyc = 0;
    aborted = 1'b0;
    build_model(total, sh, relu);
    zero_frame = (total == 0);
    rand_ready = rnd;
    beats_seen = 0;
    done_seen = 1'b0;

    acc_valid = 1'b1;
    acc_data = 32'h1234_5678;
    @(negedge CLK);
    check({tag, "_idle_ready"}, 64'(acc_ready), 64'(0));
    @(posedge CLK); #1;
    cfg_start = 1'b1;
    cfg_out_ch = 9'(ch);
    cfg_feature_length = 6'(len);
    cfg_shift = 5'(sh);
    cfg_relu_en = relu;
    acc_valid = 1'b0;
    @(posedge CLK); #1;
    cfg_start = 1'b0;

    while (i < total && cyc < 1000 && !aborted) begin
      acc_valid = 1'b1;
      acc_data = stim[i];
      @(negedge CLK);
      acc = acc_valid && acc_ready;
      @(posedge CLK); #1;
      cyc++;
      if (acc) i++;
      if (abort_after > 0 && beats_seen >= abort_after) begin
        check({tag, "_busy_before_rst"}, 64'(busy), 64'(1));
        acc_valid = 1'b0;
        #2;
        RESET = 1'b1;
        #1;
        check({tag, "_rst_tvalid"}, 64'(M_AXIS_TVALID), 64'(0));
        check({tag, "_rst_busy"}, 64'(busy), 64'(0));
        exp_q.delete();
        aborted = 1'b1;
      end
    end

    if (aborted) begin
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
    end else begin
      check({tag, "_fed_all"}, 64'(i), 64'(total));
      acc_valid = 1'b1;
      acc_data = 32'h0000_007F;
      cyc = 0;
      while (!done_seen && cyc < 1000) begin
        @(negedge CLK);
        check({tag, "_ready_after_last"}, 64'(acc_ready), 64'(0));
        @(posedge CLK); #1;
        cyc++;
      end
      check({tag, "_done_seen"}, 64'(done_seen), 64'(1));
      check({tag, "_all_beats"}, 64'(exp_q.size()), 64'(0));
    end
    acc_valid = 1'b0;
    rand_ready = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge CLK);
    check("rst_outputs",
          64'({M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, M_AXIS_TUSER, acc_ready, busy, done}),
          64'(0));
    @(posedge CLK); #1;
    RESET = 1'b0;

    stim = '{32'sd1, -32'sd1, 32'sd127, -32'sd128};
    run_frame(1, 2, 0, 1'b0, 1'b0, 0, "f1");
    check("f1_literal", 64'(last_hs), 64'({32'h807F_FF01, 4'hF, 1'b1, 1'b1}));
    check("f1_beats", 64'(beats_seen), 64'(1));

    stim = '{32'h0000_07FF, 32'hFFFF_F000, 32'd8, 32'd7};
    run_frame(1, 2, 4, 1'b0, 1'b0, 0, "f2");
    check("f2_literal", 64'(last_hs), 64'({32'h0001_807F, 4'hF, 1'b1, 1'b1}));

    stim = '{-32'sd5, 32'sd3, -32'sd1, 32'sd200};
    run_frame(1, 2, 0, 1'b1, 1'b0, 0, "f3");
    check("f3_literal", 64'(last_hs), 64'({32'h7F00_0300, 4'hF, 1'b1, 1'b1}));

    stim = '{32'sd10, 32'sd20, 32'sd30};
    run_frame(3, 1, 0, 1'b0, 1'b0, 0, "f4");
    check("f4_literal", 64'(last_hs), 64'({32'h001E_140A, 4'h7, 1'b1, 1'b1}));

    stim.delete();
    for (int k = 0; k < 18; k++) stim.push_back(32'(k * 37 - 300));
    run_frame(2, 3, 3, 1'b1, 1'b1, 0, "f5");
    check("f5_literal", 64'(last_hs), 64'({32'h0000_2925, 4'h3, 1'b1, 1'b0}));
    check("f5_beats", 64'(beats_seen), 64'(5));

    stim.delete();
    for (int k = 0; k < 64; k++) stim.push_back(32'(k));
    run_frame(4, 4, 0, 1'b0, 1'b1, 0, "f6");
    check("f6_literal", 64'(last_hs), 64'({32'h3F3E_3D3C, 4'hF, 1'b1, 1'b0}));
    check("f6_beats", 64'(beats_seen), 64'(16));

    run_frame(4, 4, 0, 1'b0, 1'b1, 5, "f7");

    run_frame(0, 4, 0, 1'b0, 1'b0, 0, "f8");
    check("f8_beats", 64'(beats_seen), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
